// File: rtl/pattern_scan_ctrl.sv
// Programmable serial pattern scanner with run control: one scan run per start,
// optional overlapping matches, a match counter and a stop-after-N-matches limit.
module pattern_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             x,
    output logic             y,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_HIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   win_q, win_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   lim_q, lim_d;

    logic               scanning;
    logic [PAT_W-1:0]   win_nxt;
    logic [FW-1:0]      fill_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match;
    logic               limit_hit;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its peers regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            lim_q   <= lim_d;
        end
    end

    // Match evaluation on the window as it will look after this edge's bit.
    always_comb begin
        scanning  = (state_q == S_HUNT) || (state_q == S_HIT);
        win_nxt   = {win_q[PAT_W-2:0], x};
        fill_nxt  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        cnt_inc   = cnt_q + 1'b1;
        match     = scanning && !abort && (fill_nxt == FILL_FULL) && (win_nxt == pat_q);
        limit_hit = match && (lim_q != '0) && (cnt_inc == lim_q);
    end

    // NOTE: every always_comb output is given a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        lim_d  = lim_q;
        if (state_q == S_IDLE && start) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            lim_d  = cfg_limit;
            win_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (scanning && !abort) begin
            win_d = win_nxt;
            if (match) begin
                // Non-overlap discards the matched bits by restarting the fill.
                fill_d = ovl_q ? FILL_FULL : '0;
                cnt_d  = cnt_inc;
            end else begin
                fill_d = fill_nxt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (start) state_d = S_HUNT;
            S_HUNT, S_HIT: begin
                if (abort)          state_d = S_IDLE;
                else if (limit_hit) state_d = S_DONE;
                else if (match)     state_d = S_HIT;
                else                state_d = S_HUNT;
            end
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        y           = (state_q == S_HIT) || (state_q == S_DONE);
        done        = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        match_count = cnt_q;
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed vector table, reset
// corner sequence, then random traffic against a queue-based reference model.
module tb_pattern_scan_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort, x;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             y, busy, done;
    logic [CNT_W-1:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .x(x), .y(y), .busy(busy), .done(done), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PAT_W-1:0] pat;
        logic             ovl;
        logic [CNT_W-1:0] lim;
        logic             st, ab, xb;
        logic             ey, eb, ed;
        logic [CNT_W-1:0] ec;
        string            tag;
    } vec_t;

    vec_t             vq[$];
    logic [PAT_W-1:0] cur_pat;
    logic             cur_ovl;
    logic [CNT_W-1:0] cur_lim;
    string            cur_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic ey, input logic eb,
                              input logic ed, input logic [CNT_W-1:0] ec);
        check({name, ".y"},     32'(y),           32'(ey));
        check({name, ".busy"},  32'(busy),        32'(eb));
        check({name, ".done"},  32'(done),        32'(ed));
        check({name, ".count"}, 32'(match_count), 32'(ec));
    endtask

    task automatic add(input logic st, input logic ab, input logic xb, input logic ey,
                       input logic eb, input logic ed, input logic [CNT_W-1:0] ec);
        vec_t v;
        v.pat = cur_pat; v.ovl = cur_ovl; v.lim = cur_lim;
        v.st = st; v.ab = ab; v.xb = xb;
        v.ey = ey; v.eb = eb; v.ed = ed; v.ec = ec;
        v.tag = cur_tag;
        vq.push_back(v);
    endtask

    // Drive inputs between edges, clock once, check 1 time unit after the edge.
    task automatic step(input logic st, input logic ab, input logic xb);
        start = st; abort = ab; x = xb;
        @(posedge clk);
        #1;
    endtask

    // Reference model: bits received since the last fill restart, compared
    // element-wise against the latched pattern.
    logic             m_active, m_done_cyc, m_y;
    logic [CNT_W-1:0] m_cnt, m_lim;
    logic [PAT_W-1:0] m_pat;
    logic             m_ovl;
    logic             hist[$];

    task automatic model_reset();
        m_active = 0; m_done_cyc = 0; m_y = 0; m_cnt = '0;
        m_lim = '0; m_pat = '0; m_ovl = 0;
        hist.delete();
    endtask

    function automatic logic tail_matches();
        int n = hist.size();
        if (n < PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++)
            if (hist[n - PAT_W + i] != m_pat[PAT_W-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (m_done_cyc) begin
            m_done_cyc = 0; m_y = 0;
        end else if (!m_active) begin
            m_y = 0;
            if (start) begin
                m_active = 1; m_pat = cfg_pattern; m_ovl = cfg_overlap;
                m_lim = cfg_limit; m_cnt = '0; hist.delete();
            end
        end else if (abort) begin
            m_active = 0; m_y = 0;
        end else begin
            hist.push_back(x);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            m_y = tail_matches();
            if (m_y) begin
                m_cnt = m_cnt + 1'b1;
                if (!m_ovl) hist.delete();
                if (m_lim != 0 && m_cnt == m_lim) begin
                    m_done_cyc = 1; m_active = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; abort = 0; x = 0;
        cfg_pattern = '0; cfg_overlap = 0; cfg_limit = '0;
        #2;
        check_outs("reset", 0, 0, 0, 8'd0);
        #10 rst = 1'b0;

        // Non-overlap 1010 stream: matches after bits 4 and 8 only.
        cur_pat = 4'b1010; cur_ovl = 0; cur_lim = 8'd0; cur_tag = "nonovl";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,0, 1,1,0,1);
        add(0,0,1, 0,1,0,1); add(0,0,0, 0,1,0,1); add(0,0,1, 0,1,0,1); add(0,0,0, 1,1,0,2);
        add(0,1,0, 0,0,0,2);
        // Overlap: extra match after bit 6.
        cur_ovl = 1; cur_tag = "ovl";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,0, 1,1,0,1);
        add(0,0,1, 0,1,0,1); add(0,0,0, 1,1,0,2); add(0,0,1, 0,1,0,2); add(0,0,0, 1,1,0,3);
        add(0,1,0, 0,0,0,3);
        // 1111 overlap: y stays high on back-to-back matches.
        cur_pat = 4'b1111; cur_tag = "ones_ovl";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0);
        add(0,0,1, 1,1,0,1); add(0,0,1, 1,1,0,2); add(0,0,1, 1,1,0,3);
        add(0,1,0, 0,0,0,3);
        cur_ovl = 0; cur_tag = "ones_nonovl";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,1, 0,1,0,0);
        add(0,0,1, 1,1,0,1); add(0,0,1, 0,1,0,1); add(0,0,1, 0,1,0,1);
        add(0,1,0, 0,0,0,1);
        // Limit 2: start while busy ignored, abort in DONE ignored, third 1010 ignored.
        cur_pat = 4'b1010; cur_lim = 8'd2; cur_tag = "limit";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,0,0, 1,1,0,1);
        add(0,0,1, 0,1,0,1); add(1,0,0, 0,1,0,1); add(0,0,1, 0,1,0,1); add(0,0,0, 1,1,1,2);
        add(0,1,1, 0,0,0,2); add(0,0,0, 0,0,0,2); add(0,0,1, 0,0,0,2); add(0,0,0, 0,0,0,2);
        // Abort on the edge that samples the final pattern bit.
        cur_lim = 8'd0; cur_tag = "abort";
        add(1,0,0, 0,1,0,0);
        add(0,0,1, 0,1,0,0); add(0,0,0, 0,1,0,0); add(0,0,1, 0,1,0,0); add(0,1,0, 0,0,0,0);
        add(0,0,0, 0,0,0,0);

        foreach (vq[i]) begin
            cfg_pattern = vq[i].pat; cfg_overlap = vq[i].ovl; cfg_limit = vq[i].lim;
            step(vq[i].st, vq[i].ab, vq[i].xb);
            check_outs($sformatf("%s[%0d]", vq[i].tag, i), vq[i].ey, vq[i].eb, vq[i].ed, vq[i].ec);
        end

        // Asynchronous reset mid-run, then a fresh run with a different pattern.
        cfg_pattern = 4'b1010; cfg_overlap = 0; cfg_limit = 8'd0;
        step(1,0,0);
        step(0,0,1); step(0,0,0); step(0,0,1); step(0,0,0);
        check_outs("rst_pre", 1, 1, 0, 8'd1);
        #2 rst = 1'b1;
        #1 check_outs("rst_async", 0, 0, 0, 8'd0);
        #2 rst = 1'b0;
        step(0,0,1);
        check_outs("rst_stay_idle", 0, 0, 0, 8'd0);
        cfg_pattern = 4'b0110;
        step(1,0,0);
        step(0,0,0); step(0,0,1); step(0,0,1);
        check_outs("p0110_pre", 0, 1, 0, 8'd0);
        step(0,0,0);
        check_outs("p0110_hit", 1, 1, 0, 8'd1);
        step(0,1,0);
        check_outs("p0110_end", 0, 0, 0, 8'd1);

        // Random traffic against the reference model.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) begin
                cfg_pattern = PAT_W'($urandom);
                cfg_overlap = 1'($urandom_range(1));
                cfg_limit   = CNT_W'($urandom_range(4));
            end
            start = ($urandom_range(3) == 0);
            abort = ($urandom_range(39) == 0);
            x     = 1'($urandom_range(1));
            model_step();
            @(posedge clk);
            #1;
            check_outs($sformatf("rand[%0d]", i), m_y, m_active | m_done_cyc, m_done_cyc, m_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
